// File: rtl/play_ctrl_pkg.sv
// Shared play-state encodings for the play controller, note player and display logic.
package play_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } play_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse detector for a debounced button level; one pulse per press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  output logic pulse_o
);

  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 1'b0;
    else     hist_q <= lvl_i;
  end

  // Combinational so the FSM acts on the same edge that sees the new level.
  assign pulse_o = lvl_i & ~hist_q;

endmodule

// File: rtl/play_ctrl_fsm.sv
// Play/pause/stop state and song index controller with prioritised button actions
// and a one-cycle restart pulse for the song reader and note player.
module play_ctrl_fsm
  import play_ctrl_pkg::*;
#(
  parameter  int NUM_SONGS = 4,
  localparam int SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              song_done,
  input  logic              repeat_all,
  output logic [1:0]        play_state,
  output logic [SONG_W-1:0] song_index,
  output logic              reset_player,
  output logic              playing
);

  localparam logic [SONG_W-1:0] LAST_IDX = SONG_W'(NUM_SONGS - 1);
  localparam logic [SONG_W-1:0] ONE_IDX  = SONG_W'(1);

  logic play_p, stop_p, next_p, prev_p;

  btn_edge u_edge_play (.clk(clk), .rst(rst), .lvl_i(btn_play), .pulse_o(play_p));
  btn_edge u_edge_stop (.clk(clk), .rst(rst), .lvl_i(btn_stop), .pulse_o(stop_p));
  btn_edge u_edge_next (.clk(clk), .rst(rst), .lvl_i(btn_next), .pulse_o(next_p));
  btn_edge u_edge_prev (.clk(clk), .rst(rst), .lvl_i(btn_prev), .pulse_o(prev_p));

  play_state_e       state_q, state_d;
  logic [SONG_W-1:0] idx_q, idx_d;
  logic              rp_q, rp_d;
  logic              playing_q;

  // One action per cycle: stop > next > prev > play > song_done; losers are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rp_d    = 1'b0;
    if (stop_p) begin
      state_d = ST_STOP;
      rp_d    = 1'b1;
    end else if (next_p) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + ONE_IDX;
      rp_d  = 1'b1;
    end else if (prev_p) begin
      idx_d = (idx_q == '0) ? LAST_IDX : idx_q - ONE_IDX;
      rp_d  = 1'b1;
    end else if (play_p) begin
      case (state_q)
        ST_STOP:  state_d = ST_PLAY;
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_PLAY;
        default:  state_d = ST_STOP;
      endcase
    end else if (song_done && (state_q == ST_PLAY)) begin
      rp_d = 1'b1;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (!repeat_all) state_d = ST_STOP;
      end else begin
        idx_d = idx_q + ONE_IDX;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      idx_q     <= '0;
      rp_q      <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rp_q      <= rp_d;
      playing_q <= (state_d == ST_PLAY);
    end
  end

  assign play_state   = state_q;
  assign song_index   = idx_q;
  assign reset_player = rp_q;
  assign playing      = playing_q;

endmodule

// File: tb/tb_play_ctrl_fsm.sv
// Directed vector bench for play_ctrl_fsm (4-song build plus a 5-song build).
module tb_play_ctrl_fsm;
  import play_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_play = 1'b0, btn_stop = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
  logic       song_done = 1'b0, repeat_all = 1'b0;
  logic [1:0] play_state;
  logic [1:0] song_index;
  logic       reset_player, playing;

  logic       n5_next = 1'b0, n5_prev = 1'b0, n5_zero = 1'b0;
  logic [1:0] ps5;
  logic [2:0] idx5;
  logic       rp5, pl5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  play_ctrl_fsm #(.NUM_SONGS(4)) dut (
    .clk(clk), .rst(rst), .btn_play(btn_play), .btn_stop(btn_stop),
    .btn_next(btn_next), .btn_prev(btn_prev), .song_done(song_done),
    .repeat_all(repeat_all), .play_state(play_state), .song_index(song_index),
    .reset_player(reset_player), .playing(playing)
  );

  play_ctrl_fsm #(.NUM_SONGS(5)) dut5 (
    .clk(clk), .rst(rst), .btn_play(n5_zero), .btn_stop(n5_zero),
    .btn_next(n5_next), .btn_prev(n5_prev), .song_done(n5_zero),
    .repeat_all(n5_zero), .play_state(ps5), .song_index(idx5),
    .reset_player(rp5), .playing(pl5)
  );

  typedef struct {
    logic       pl, st, nx, pv, dn, ra;
    logic [1:0] e_st;
    logic [1:0] e_idx;
    logic       e_rp;
  } vec_t;

  localparam int NV = 47;
  vec_t vt[NV];

  function automatic vec_t mk(logic pl, logic st, logic nx, logic pv, logic dn, logic ra,
                              logic [1:0] es, logic [1:0] ei, logic er);
    vec_t v;
    v.pl = pl; v.st = st; v.nx = nx; v.pv = pv; v.dn = dn; v.ra = ra;
    v.e_st = es; v.e_idx = ei; v.e_rp = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic pl, input logic st, input logic nx, input logic pv,
                       input logic dn, input logic ra);
    @(negedge clk);
    btn_play = pl; btn_stop = st; btn_next = nx; btn_prev = pv;
    song_done = dn; repeat_all = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [1:0] es, input logic [1:0] ei, input logic er);
    chk({nm, ".state"}, 32'(play_state), 32'(es));
    chk({nm, ".idx"}, 32'(song_index), 32'(ei));
    chk({nm, ".rp"}, 32'(reset_player), 32'(er));
    chk({nm, ".playing"}, 32'(playing), 32'(es == ST_PLAY));
  endtask

  initial begin
    // play toggling, no restart pulse
    vt[0]  = mk(1,0,0,0,0,0, ST_PLAY, 0, 0);
    vt[1]  = mk(0,0,0,0,0,0, ST_PLAY, 0, 0);
    vt[2]  = mk(1,0,0,0,0,0, ST_PAUSE,0, 0);
    vt[3]  = mk(0,0,0,0,0,0, ST_PAUSE,0, 0);
    vt[4]  = mk(1,0,0,0,0,0, ST_PLAY, 0, 0);
    vt[5]  = mk(0,0,0,0,0,0, ST_PLAY, 0, 0);
    // prev wraps, song_done wraps with repeat
    vt[6]  = mk(0,0,0,1,0,0, ST_PLAY, 3, 1);
    vt[7]  = mk(0,0,0,0,0,0, ST_PLAY, 3, 0);
    vt[8]  = mk(0,0,0,0,1,1, ST_PLAY, 0, 1);
    vt[9]  = mk(0,0,1,0,0,0, ST_PLAY, 1, 1);
    vt[10] = mk(0,0,0,0,0,0, ST_PLAY, 1, 0);
    vt[11] = mk(0,0,1,0,0,0, ST_PLAY, 2, 1);
    vt[12] = mk(0,0,0,0,0,0, ST_PLAY, 2, 0);
    vt[13] = mk(0,0,1,0,0,0, ST_PLAY, 3, 1);
    // last song done without repeat stops
    vt[14] = mk(0,0,0,0,1,0, ST_STOP, 0, 1);
    vt[15] = mk(0,0,0,0,1,0, ST_STOP, 0, 0);
    vt[16] = mk(1,0,0,0,0,0, ST_PLAY, 0, 0);
    vt[17] = mk(0,0,0,0,0,0, ST_PLAY, 0, 0);
    vt[18] = mk(1,0,0,0,0,0, ST_PAUSE,0, 0);
    vt[19] = mk(0,0,0,0,0,0, ST_PAUSE,0, 0);
    // navigation in PAUSE keeps state and pulses
    vt[20] = mk(0,0,1,0,0,0, ST_PAUSE,1, 1);
    vt[21] = mk(0,0,0,0,0,0, ST_PAUSE,1, 0);
    vt[22] = mk(0,0,0,1,0,0, ST_PAUSE,0, 1);
    vt[23] = mk(0,0,0,0,0,0, ST_PAUSE,0, 0);
    vt[24] = mk(0,0,0,1,0,0, ST_PAUSE,3, 1);
    vt[25] = mk(0,0,0,0,0,0, ST_PAUSE,3, 0);
    vt[26] = mk(0,0,1,0,0,0, ST_PAUSE,0, 1);
    vt[27] = mk(0,0,0,0,1,1, ST_PAUSE,0, 0);
    // stop beats play; stop in STOP pulses again
    vt[28] = mk(1,1,0,0,0,0, ST_STOP, 0, 1);
    vt[29] = mk(0,0,0,0,0,0, ST_STOP, 0, 0);
    vt[30] = mk(0,1,0,0,0,0, ST_STOP, 0, 1);
    vt[31] = mk(0,0,0,0,0,0, ST_STOP, 0, 0);
    vt[32] = mk(1,0,0,0,0,0, ST_PLAY, 0, 0);
    // next held 5 cycles advances once
    vt[33] = mk(0,0,1,0,0,0, ST_PLAY, 1, 1);
    vt[34] = mk(0,0,1,0,0,0, ST_PLAY, 1, 0);
    vt[35] = mk(0,0,1,0,0,0, ST_PLAY, 1, 0);
    vt[36] = mk(0,0,1,0,0,0, ST_PLAY, 1, 0);
    vt[37] = mk(0,0,1,0,0,0, ST_PLAY, 1, 0);
    vt[38] = mk(0,0,0,0,0,0, ST_PLAY, 1, 0);
    // song_done with next advances once
    vt[39] = mk(0,0,1,0,1,1, ST_PLAY, 2, 1);
    vt[40] = mk(0,0,0,0,0,0, ST_PLAY, 2, 0);
    vt[41] = mk(0,0,1,1,0,0, ST_PLAY, 3, 1);
    vt[42] = mk(0,0,0,0,0,0, ST_PLAY, 3, 0);
    vt[43] = mk(1,0,0,1,0,0, ST_PLAY, 2, 1);
    vt[44] = mk(0,0,0,0,0,0, ST_PLAY, 2, 0);
    vt[45] = mk(0,1,0,0,0,0, ST_STOP, 2, 1);
    vt[46] = mk(0,0,0,0,0,0, ST_STOP, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", ST_STOP, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].pl, vt[i].st, vt[i].nx, vt[i].pv, vt[i].dn, vt[i].ra);
      chk_out($sformatf("vec%0d", i), vt[i].e_st, vt[i].e_idx, vt[i].e_rp);
    end

    // Asynchronous reset mid-PLAY at idx 2, observed before the next clock edge
    apply(1,0,0,0,0,0);
    chk_out("pre_areset", ST_PLAY, 2, 0);
    apply(0,0,0,0,0,0);
    #2 rst = 1'b1;
    #1;
    chk_out("areset", ST_STOP, 0, 0);

    // Play held high across reset release counts as a press
    btn_play = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("held_rst_play", ST_PLAY, 0, 0);
    @(posedge clk);
    #1;
    chk_out("held_rst_hold", ST_PLAY, 0, 0);
    apply(0,0,0,0,0,0);

    // Five-song build: next wraps 4 -> 0, prev wraps 0 -> 4
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); n5_next = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("n5_next%0d", k), 32'(idx5), 32'((k + 1) % 5));
      chk($sformatf("n5_rp%0d", k), 32'(rp5), 32'd1);
      @(negedge clk); n5_next = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("n5_range%0d", k), 32'(idx5 < 3'd5), 32'd1);
    end
    @(negedge clk); n5_prev = 1'b1;
    @(posedge clk); #1;
    chk("n5_prev_wrap", 32'(idx5), 32'd4);
    chk("n5_state", 32'(ps5), 32'(ST_STOP));
    @(negedge clk); n5_prev = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/play_ctrl_fsm.md
Name: play_ctrl_fsm

Overview:
Parametrised successor to the single-button play-state controller. It tracks play/pause/stop state and the current song index for the music player. Inputs are four debounced front-panel buttons and a song-done pulse from the song reader. It drives the state and index to the song reader and note player, plus a one-cycle restart pulse whenever the song changes or playback stops.

Parameters:
NUM_SONGS, 4, number of songs in ROM; legal range >= 2
SONG_W, $clog2(NUM_SONGS) (min 1), width of song_index; derived, not overridden

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  reset; asynchronous, active-high
btn_play  input  1  debounced play/pause button, level
btn_stop  input  1  debounced stop button, level
btn_next  input  1  debounced next-song button, level
btn_prev  input  1  debounced previous-song button, level
song_done  input  1  one-cycle pulse from song reader: current song finished
repeat_all  input  1  mode level: 1 = wrap to song 0 after last song, 0 = stop after last
play_state  output  2  00 STOP, 01 PLAY, 10 PAUSE (11 never driven)
song_index  output  SONG_W  current song, 0..NUM_SONGS-1
reset_player  output  1  one-cycle pulse: song reader/note player restart at note 0
playing  output  1  registered, equals (play_state==PLAY)

Behaviour:
- Reset: async assert forces play_state=STOP, song_index=0, reset_player=0, playing=0, all button history regs=0.
- Button held high through reset release therefore counts as a press at the first edge after release.
- Edge detect: each button has a history reg. A press is detected at a rising clk edge where btn=1 and history=0.
- A held button yields exactly one press. A one-cycle-wide press is caught.
- Latency: outputs update at the same clk edge that detects the press or samples song_done high, i.e. visible 1 cycle after the input goes high.
- One action per cycle. Priority: stop > next > prev > play > song_done. Lower-priority presses in the same cycle are discarded, not queued.
- song_done coincident with next or prev therefore advances once, not twice.
- stop: any state -> STOP; song_index unchanged; reset_player=1 for 1 cycle. In STOP, stop pulses reset_player again (harmless).
- play: STOP->PLAY, PLAY->PAUSE, PAUSE->PLAY. No reset_player pulse.
- next: song_index = (idx==NUM_SONGS-1) ? 0 : idx+1; play_state unchanged (PLAY/PAUSE/STOP all keep state); reset_player=1.
- prev: song_index = (idx==0) ? NUM_SONGS-1 : idx-1; play_state unchanged; reset_player=1.
- song_done in PLAY, idx < NUM_SONGS-1: idx+1, stay PLAY, reset_player=1.
- song_done in PLAY, idx == NUM_SONGS-1, repeat_all=1: idx=0, stay PLAY, reset_player=1.
- song_done in PLAY, idx == NUM_SONGS-1, repeat_all=0: idx=0, ->STOP, reset_player=1.
- song_done in PAUSE or STOP: ignored.
- reset_player is 0 in every cycle without a qualifying action. Never high two consecutive cycles unless two separate actions occur.
- Index arithmetic is modulo NUM_SONGS. Comparisons use NUM_SONGS-1 explicitly, so non-power-of-2 counts never reach illegal indices.
- repeat_all is sampled only when song_done is taken; changing it mid-song has no other effect.
- Async reset mid-song: immediate return to reset values; no reset_player pulse generated.

Decomposition:
- Shared package play_ctrl_pkg: play_state encodings ST_STOP=2'b00, ST_PLAY=2'b01, ST_PAUSE=2'b10. Also used by note player and display logic.
- Sub-module btn_edge: rising-edge pulse detector with clk, rst (async high), level in, pulse out. Instantiated 4 times.
- FSM, index counter and priority encode stay in play_ctrl_fsm.

Test Plan:
- Reset, then play press 1 cycle at t=60ns -> play_state 00->01 at next edge; again -> 10; again -> 01; reset_player stays 0 throughout.
- NUM_SONGS=4, PLAY, idx=3, song_done with repeat_all=1 -> idx=0, play_state=01, reset_player high 1 cycle. Same with repeat_all=0 -> idx=0, play_state=00.
- prev at idx=0 -> idx=3. next at idx=3 -> idx=0. In PAUSE, state stays 10 and reset_player pulses each time.
- btn_next held 5 cycles -> idx advances exactly once. btn_stop and btn_play same cycle in PLAY -> STOP, play/pause press discarded.
- PLAY idx=1: song_done and btn_next same cycle -> idx=2 (not 3), single reset_player pulse. song_done in PAUSE -> no change.
- Assert rst mid-PLAY at idx=2 -> outputs STOP/0/0 immediately without waiting for clk. NUM_SONGS=5 build: next from idx=4 -> 0; index never reaches 5..7.
